// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types, funct3 encodings and load-extension helper for the
//            load/store unit.
// Contents : lsu_state_e, lsu_size_e, F3_* constants, f3_size(), load_extend()
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access width is encoded in funct3[1:0]; the illegal 2'b11 maps to word
  // and is rejected separately by the legality check.
  function automatic lsu_size_e f3_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   res = {{24{b[7]}}, b};
      F3_LH:   res = {{16{h[15]}}, h};
      F3_LBU:  res = {24'b0, b};
      F3_LHU:  res = {16'b0, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator_if
// Purpose  : Core-side and memory-side handshake bundle of the LSU.
// Modports : master - the LSU (accepts core ops, issues memory requests)
//            slave  - the environment (core + data memory)
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_initiator_if;
  logic        core_valid;
  logic        core_ready;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_done;
  logic        core_err;
  logic [31:0] core_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  core_valid, core_we, core_funct3, core_addr, core_wdata,
    output core_ready, core_done, core_err, core_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    output core_valid, core_we, core_funct3, core_addr, core_wdata,
    input  core_ready, core_done, core_err, core_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational lane logic: byte enables and replicated write data
//            for a request, extracted/extended data for a load response.
// Ports    : req_size_i, req_lane_i, req_wdata_i -> req_be_o, req_wdata_o
//            rsp_funct3_i, rsp_lane_i, rsp_word_i -> rsp_data_o
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import riscv_pkg::*;
(
  input  lsu_size_e   req_size_i,
  input  logic [1:0]  req_lane_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [1:0]  rsp_lane_i,
  input  logic [31:0] rsp_word_i,
  output logic [31:0] rsp_data_o
);

  // Data is replicated across all lanes so the memory only needs the enables.
  always_comb begin
    req_be_o    = 4'b1111;
    req_wdata_o = req_wdata_i;
    case (req_size_i)
      SZ_B: begin
        req_be_o    = 4'b0001 << req_lane_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        req_be_o    = 4'b0011 << req_lane_i;
        req_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rsp_data_o = load_extend(rsp_funct3_i, rsp_lane_i, rsp_word_i);

endmodule
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Purpose  : Single-outstanding load/store initiator between execute stage and
//            byte-addressed data memory. Checks alignment, range and funct3,
//            issues a word-aligned request and extends load data.
// Ports    : clk, rst_n (async active-low)
//            bus (lsu_mem_initiator_if.master) - core and memory handshakes
// Params   : MEM_BYTES - memory size in bytes, TIMEOUT - response wait limit
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 40,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_mem_initiator_if.master  bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_ready_q, core_ready_d;
  logic              core_done_q, core_done_d;
  logic              core_err_q, core_err_d;
  logic [31:0]       core_rdata_q, core_rdata_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  lsu_size_e   size_w;
  logic [2:0]  nbytes_w;
  logic [32:0] end_w;
  logic        f3_ok_w, misal_w, range_w, reject_w;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, ld_data_w;

  // Request qualification, evaluated on the core's live inputs in IDLE.
  always_comb begin
    size_w = f3_size(bus.core_funct3);
    case (size_w)
      SZ_B:    nbytes_w = 3'd1;
      SZ_H:    nbytes_w = 3'd2;
      default: nbytes_w = 3'd4;
    endcase
    // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
    if (bus.core_we)
      f3_ok_w = (bus.core_funct3 == F3_LB) || (bus.core_funct3 == F3_LH) ||
                (bus.core_funct3 == F3_LW);
    else
      f3_ok_w = (bus.core_funct3 == F3_LB) || (bus.core_funct3 == F3_LH) ||
                (bus.core_funct3 == F3_LW) || (bus.core_funct3 == F3_LBU) ||
                (bus.core_funct3 == F3_LHU);
    misal_w = ((size_w == SZ_H) && bus.core_addr[0]) ||
              ((size_w == SZ_W) && (bus.core_addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap past the range check.
    end_w    = {1'b0, bus.core_addr} + 33'(nbytes_w);
    range_w  = end_w > 33'(MEM_BYTES);
    reject_w = !f3_ok_w || misal_w || range_w;
  end

  lsu_lane_align u_lane_align (
    .req_size_i   (size_w),
    .req_lane_i   (bus.core_addr[1:0]),
    .req_wdata_i  (bus.core_wdata),
    .req_be_o     (be_w),
    .req_wdata_o  (wdata_w),
    .rsp_funct3_i (funct3_q),
    .rsp_lane_i   (lane_q),
    .rsp_word_i   (bus.mem_rdata),
    .rsp_data_o   (ld_data_w)
  );

  always_comb begin
    state_d         = state_q;
    funct3_d        = funct3_q;
    lane_d          = lane_q;
    cnt_d           = cnt_q;
    core_ready_d    = core_ready_q;
    core_done_d     = 1'b0;
    core_err_d      = core_err_q;
    core_rdata_d    = core_rdata_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.core_valid && core_ready_q) begin
          core_ready_d = 1'b0;
          funct3_d     = bus.core_funct3;
          lane_d       = bus.core_addr[1:0];
          if (reject_w) begin
            state_d      = DONE;
            core_done_d  = 1'b1;
            core_err_d   = 1'b1;
            core_rdata_d = '0;
          end else begin
            state_d         = REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = bus.core_we;
            mem_addr_d      = {bus.core_addr[31:2], 2'b00};
            mem_be_d        = be_w;
            mem_wdata_d     = bus.core_we ? wdata_w : '0;
          end
        end
      end

      REQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (mem_we_q) begin
            state_d      = DONE;
            core_done_d  = 1'b1;
            core_err_d   = 1'b0;
            core_rdata_d = '0;
          end else begin
            state_d = WAIT_RSP;
            cnt_d   = '0;
          end
        end
      end

      WAIT_RSP: begin
        // A response on the final wait cycle takes priority over timeout.
        if (bus.mem_rsp_valid) begin
          state_d      = DONE;
          core_done_d  = 1'b1;
          core_err_d   = 1'b0;
          core_rdata_d = ld_data_w;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          core_done_d  = 1'b1;
          core_err_d   = 1'b1;
          core_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d      = IDLE;
        core_ready_d = 1'b1;
        core_err_d   = 1'b0;
        core_rdata_d = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      funct3_q        <= '0;
      lane_q          <= '0;
      cnt_q           <= '0;
      core_ready_q    <= 1'b1;
      core_done_q     <= 1'b0;
      core_err_q      <= 1'b0;
      core_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_be_q        <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      funct3_q        <= funct3_d;
      lane_q          <= lane_d;
      cnt_q           <= cnt_d;
      core_ready_q    <= core_ready_d;
      core_done_q     <= core_done_d;
      core_err_q      <= core_err_d;
      core_rdata_q    <= core_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign bus.core_ready    = core_ready_q;
  assign bus.core_done     = core_done_q;
  assign bus.core_err      = core_err_q;
  assign bus.core_rdata    = core_rdata_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_be        = mem_be_q;
  assign bus.mem_wdata     = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Purpose  : Directed self-checking bench for lsu_mem_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_initiator;
  import riscv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lsu_mem_initiator_if bus ();

  lsu_mem_initiator #(
    .MEM_BYTES (40),
    .TIMEOUT   (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Results captured by run_op. Latency counts clock edges after the accept edge
  // until core_done is observed.
  int          r_lat, r_nreq;
  logic        r_err, r_we, r_stable, r_done;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;

  // rdy_delay: cycles mem_req_ready stays low while a request is pending.
  // rsp_wait : wait cycles before mem_rsp_valid (-1 = never respond).
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_delay, input int rsp_wait,
                        input logic [31:0] rword);
    bit hs_prev;
    bit waiting;
    int w;
    hs_prev = 0; waiting = 0; w = 0;
    r_nreq = 0; r_stable = 1'b1; r_done = 1'b0; r_lat = -1;
    r_err = 1'b0; r_rdata = '0; r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    bus.core_valid    = 1'b1;
    bus.core_we       = we;
    bus.core_funct3   = f3;
    bus.core_addr     = addr;
    bus.core_wdata    = wdata;
    bus.mem_rdata     = rword;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    step();
    bus.core_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (hs_prev) waiting = 1;
      hs_prev = 0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if (bus.core_done) begin
        r_done  = 1'b1;
        r_lat   = k;
        r_err   = bus.core_err;
        r_rdata = bus.core_rdata;
        break;
      end
      if (bus.mem_req_valid) begin
        r_nreq++;
        if (r_nreq == 1) begin
          r_addr = bus.mem_addr; r_wdata = bus.mem_wdata; r_be = bus.mem_be; r_we = bus.mem_we;
        end else if (bus.mem_addr !== r_addr || bus.mem_wdata !== r_wdata ||
                     bus.mem_be !== r_be || bus.mem_we !== r_we) begin
          r_stable = 1'b0;
        end
        if (r_nreq > rdy_delay) begin
          bus.mem_req_ready = 1'b1;
          hs_prev = 1;
        end
      end
      if (waiting) begin
        w++;
        if (w == rsp_wait + 1) bus.mem_rsp_valid = 1'b1;
      end
      step();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    chk_eq({tag, "_done_seen"}, 32'(r_done), 32'd1);
    step();
  endtask

  bit saw_done;

  initial begin
    bus.core_valid    = 1'b0;
    bus.core_we       = 1'b0;
    bus.core_funct3   = 3'b000;
    bus.core_addr     = '0;
    bus.core_wdata    = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    chk_eq("rst_core_ready", 32'(bus.core_ready), 32'd1);
    chk_eq("rst_core_done",  32'(bus.core_done), 32'd0);
    chk_eq("rst_core_err",   32'(bus.core_err), 32'd0);
    chk_eq("rst_core_rdata", bus.core_rdata, 32'h0);
    chk_eq("rst_req_valid",  32'(bus.mem_req_valid), 32'd0);
    chk_eq("rst_mem_be",     32'(bus.mem_be), 32'd0);
    chk_eq("rst_mem_addr",   bus.mem_addr, 32'h0);

    // SW to word 8, zero wait
    run_op("sw8", 1'b1, F3_LW, 32'd8, 32'hDEADBEEF, 0, 0, 32'h0);
    chk_eq("sw8_addr",  r_addr, 32'd8);
    chk_eq("sw8_be",    32'(r_be), 32'hF);
    chk_eq("sw8_wdata", r_wdata, 32'hDEADBEEF);
    chk_eq("sw8_we",    32'(r_we), 32'd1);
    chk_eq("sw8_lat",   32'(r_lat), 32'd1);
    chk_eq("sw8_err",   32'(r_err), 32'd0);
    chk_eq("sw8_rdata", r_rdata, 32'h0);

    // LB / LBU from byte 5 of a word holding 0x80 in lane 1
    run_op("lb5", 1'b0, F3_LB, 32'd5, 32'h0, 0, 0, 32'h0000_8000);
    chk_eq("lb5_addr",  r_addr, 32'd4);
    chk_eq("lb5_be",    32'(r_be), 32'h2);
    chk_eq("lb5_we",    32'(r_we), 32'd0);
    chk_eq("lb5_rdata", r_rdata, 32'hFFFF_FF80);
    chk_eq("lb5_lat",   32'(r_lat), 32'd2);
    run_op("lbu5", 1'b0, F3_LBU, 32'd5, 32'h0, 0, 0, 32'h0000_8000);
    chk_eq("lbu5_rdata", r_rdata, 32'h0000_0080);
    chk_eq("lbu5_err",   32'(r_err), 32'd0);

    // SH to upper half of word 4
    run_op("sh6", 1'b1, F3_LH, 32'd6, 32'h0000_1234, 0, 0, 32'h0);
    chk_eq("sh6_addr",  r_addr, 32'd4);
    chk_eq("sh6_be",    32'(r_be), 32'hC);
    chk_eq("sh6_wdata", r_wdata, 32'h1234_1234);

    // SB at the last legal byte
    run_op("sb39", 1'b1, F3_LB, 32'd39, 32'h0000_00A5, 0, 0, 32'h0);
    chk_eq("sb39_addr",  r_addr, 32'd36);
    chk_eq("sb39_be",    32'(r_be), 32'h8);
    chk_eq("sb39_wdata", r_wdata, 32'hA5A5_A5A5);
    chk_eq("sb39_err",   32'(r_err), 32'd0);

    // Rejected accesses: no memory request, done one edge after accept
    run_op("lh3", 1'b0, F3_LH, 32'd3, 32'h0, 0, 0, 32'h0);
    chk_eq("lh3_err",  32'(r_err), 32'd1);
    chk_eq("lh3_lat",  32'(r_lat), 32'd0);
    chk_eq("lh3_nreq", 32'(r_nreq), 32'd0);
    run_op("lw40", 1'b0, F3_LW, 32'd40, 32'h0, 0, 0, 32'h0);
    chk_eq("lw40_err",  32'(r_err), 32'd1);
    chk_eq("lw40_nreq", 32'(r_nreq), 32'd0);
    chk_eq("lw40_rdata", r_rdata, 32'h0);
    run_op("badf3", 1'b0, 3'b011, 32'd0, 32'h0, 0, 0, 32'h0);
    chk_eq("badf3_err", 32'(r_err), 32'd1);
    run_op("sbu", 1'b1, F3_LBU, 32'd0, 32'h0, 0, 0, 32'h0);
    chk_eq("sbu_err",  32'(r_err), 32'd1);
    chk_eq("sbu_nreq", 32'(r_nreq), 32'd0);

    // LW 36 with request stalled three cycles
    run_op("lw36", 1'b0, F3_LW, 32'd36, 32'h0, 3, 0, 32'hCAFE_F00D);
    chk_eq("lw36_addr",   r_addr, 32'd36);
    chk_eq("lw36_be",     32'(r_be), 32'hF);
    chk_eq("lw36_stable", 32'(r_stable), 32'd1);
    chk_eq("lw36_nreq",   32'(r_nreq), 32'd4);
    chk_eq("lw36_lat",    32'(r_lat), 32'd5);
    chk_eq("lw36_rdata",  r_rdata, 32'hCAFE_F00D);

    // Halfword extension from upper lane
    run_op("lh2", 1'b0, F3_LH, 32'd2, 32'h0, 0, 1, 32'h8001_0000);
    chk_eq("lh2_rdata", r_rdata, 32'hFFFF_8001);
    chk_eq("lh2_lat",   32'(r_lat), 32'd3);
    run_op("lhu2", 1'b0, F3_LHU, 32'd2, 32'h0, 0, 0, 32'h8001_0000);
    chk_eq("lhu2_rdata", r_rdata, 32'h0000_8001);

    // Timeout, then response landing on the timeout cycle
    run_op("lwto", 1'b0, F3_LW, 32'd0, 32'h0, 0, -1, 32'h5555_5555);
    chk_eq("lwto_err",   32'(r_err), 32'd1);
    chk_eq("lwto_lat",   32'(r_lat), 32'd17);
    chk_eq("lwto_rdata", r_rdata, 32'h0);
    run_op("lwedge", 1'b0, F3_LW, 32'd0, 32'h0, 0, 15, 32'h1122_3344);
    chk_eq("lwedge_err",   32'(r_err), 32'd0);
    chk_eq("lwedge_lat",   32'(r_lat), 32'd17);
    chk_eq("lwedge_rdata", r_rdata, 32'h1122_3344);

    // Reset while a request is stalled in REQ
    bus.core_valid = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = F3_LW;
    bus.core_addr = 32'd0; bus.mem_req_ready = 1'b0;
    step();
    bus.core_valid = 1'b0;
    chk_eq("rreq_valid_before", 32'(bus.mem_req_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rreq_valid_async", 32'(bus.mem_req_valid), 32'd0);
    chk_eq("rreq_ready_async", 32'(bus.core_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset during WAIT_RSP, then a stray late response
    bus.core_valid = 1'b1; bus.mem_req_ready = 1'b1;
    step();
    bus.core_valid = 1'b0;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    chk_eq("rwait_ready_before", 32'(bus.core_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_eq("rwait_ready_async", 32'(bus.core_ready), 32'd1);
    chk_eq("rwait_req_valid",   32'(bus.mem_req_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_rdata = 32'h9999_9999;
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    saw_done = 0;
    repeat (4) begin
      if (bus.core_done) saw_done = 1;
      step();
    end
    chk_eq("rwait_late_rsp_done", 32'(saw_done), 32'd0);
    chk_eq("rwait_idle_ready",    32'(bus.core_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the execute stage and the byte-addressed data memory.
- Accepts one load or store from the core and converts it into a word-aligned request with byte enables.
- For loads, waits for the read response, then extracts the addressed byte, half or word and sign- or zero-extends it.
- Handshaked on both sides so the memory may take any number of cycles; detects misaligned, out-of-range and timed-out accesses.

Parameters:
- MEM_BYTES, 40, number of bytes in the data memory; any access with addr+size > MEM_BYTES is an error.
- TIMEOUT, 16, maximum cycles to wait for mem_rsp_valid before an error is reported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_valid  in  1  request from core
- core_ready  out  1  high only in IDLE; request accepted when valid&&ready
- core_we  in  1  1=store, 0=load
- core_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes are errors
- core_addr  in  32  byte address (ALU result)
- core_wdata  in  32  store data (Rs2)
- core_done  out  1  one-cycle pulse when the operation completes
- core_err  out  1  valid with core_done; misaligned, out-of-range, bad funct3 or timeout
- core_rdata  out  32  extended load data, valid with core_done; 0 for stores and errors
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write strobe
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  32  little-endian read word

Behaviour:
- All outputs are registered. Reset values: core_ready=1; all other outputs 0. State resets to IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately and drops mem_req_valid asynchronously. Any response that arrives afterwards is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, on accept (core_valid && core_ready):
  - Error if any of: misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), addr+size>MEM_BYTES, or illegal funct3. On error go to DONE with err=1; no memory request is issued.
  - Otherwise latch the operation and go to REQ, with mem_req_valid=1 from the next cycle.
- Store lane formation:
  - SB: wdata={4{b}}, be=0001<<addr[1:0]
  - SH: wdata={2{h}}, be=0011<<addr[1:0]
  - SW: wdata as given, be=1111
- Loads drive be as above with mem_we=0.
- REQ: hold mem_* stable until mem_req_ready. On handshake, deassert mem_req_valid in the next cycle. A store goes to DONE; a load goes to WAIT_RSP with the timeout counter cleared. mem_rsp_valid is ignored in REQ.
- WAIT_RSP:
  - Count cycles while waiting.
  - On mem_rsp_valid: select the lane by addr[1:0], sign-extend for LB/LH or zero-extend for LBU/LHU, then go to DONE.
  - If the counter reaches TIMEOUT-1 without a response, go to DONE with err=1 and rdata=0.
  - If the response arrives on the same cycle as the timeout, the response wins and err=0.
- DONE: core_done=1 for exactly one cycle, then return to IDLE, where core_ready=1 again.
- Latency:
  - Zero-wait load: accept at T, mem_req_valid at T+1, response at T+2, core_done at T+3.
  - Zero-wait store: core_done at T+2.
  - Error: core_done at T+1.
- Only one transaction is in flight at a time; core_valid is ignored while core_ready=0.

Decomposition:
- Add to riscv_pkg:
  - lsu_state_e {IDLE, REQ, WAIT_RSP, DONE}
  - lsu_size_e {SZ_B, SZ_H, SZ_W}
  - funct3 constants F3_LB…F3_LHU
  - function load_extend(funct3, lane, word)
- One sub-module, lsu_lane_align: combinational generation of be and wdata, plus load extraction. It is reusable by the future cache path.

Test Plan:
- SW addr 8, data 0xDEADBEEF, mem_req_ready=1 -> mem_addr=8, be=1111, wdata=0xDEADBEEF; core_done at T+2, err=0.
- LB addr 5, mem_rdata=0x0000_8000 -> be=0010, core_rdata=0xFFFFFF80. LBU on the same access -> 0x00000080.
- SH addr 6, data 0x1234 -> mem_addr=4, be=1100, wdata=0x12341234. LH addr 3 -> err=1 at T+1 and no mem_req_valid.
- LW addr 40 (MEM_BYTES=40) -> err=1, no request. LW addr 36 with mem_req_ready delayed 3 cycles -> mem_* held stable, done at T+6.
- LW with no response -> err=1 after 16 WAIT cycles. Repeat with the response on the timeout cycle -> err=0 and data delivered.
- rst_n low during WAIT_RSP -> mem_req_valid=0 and core_ready=1 immediately; a late mem_rsp_valid produces no core_done.
